// File: rtl/trb_mem_arbiter.sv
// trb_mem_arbiter: shares one single-port trace RAM between a write and a read requester
// with mode-dependent preference, bounded starvation and a registered read-return path.
module trb_mem_arbiter #(
    parameter int DEPTH    = 1024,
    parameter int WIDTH    = 32,
    parameter int MAX_WAIT = 3,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = $clog2(MAX_WAIT + 1)
) (
    input  logic             CLK_I,
    input  logic             RST_NI,
    input  logic             MODE_I,
    input  logic             WR_REQ_I,
    input  logic [AW-1:0]    WR_PTR_I,
    input  logic [WIDTH-1:0] WR_DATA_I,
    output logic             WR_GNT_O,
    input  logic             RD_REQ_I,
    input  logic [AW-1:0]    RD_PTR_I,
    output logic             RD_GNT_O,
    output logic [WIDTH-1:0] RD_DATA_O,
    output logic             RD_VALID_O,
    output logic             MEM_EN_O,
    output logic             MEM_WE_O,
    output logic [AW-1:0]    MEM_ADDR_O,
    output logic [WIDTH-1:0] MEM_WDATA_O,
    input  logic [WIDTH-1:0] MEM_RDATA_I
);
    localparam logic [CW-1:0] MAXC = CW'(MAX_WAIT);

    logic [CW-1:0] wcnt, rcnt;
    logic          rd_s1;

    // a starved loser overrides the mode preference
    always_comb begin
        WR_GNT_O = WR_REQ_I & (!RD_REQ_I | (MODE_I ? wcnt == MAXC : rcnt != MAXC));
        RD_GNT_O = RD_REQ_I & !WR_GNT_O;
    end

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            wcnt        <= '0;
            rcnt        <= '0;
            MEM_EN_O    <= 1'b0;
            MEM_WE_O    <= 1'b0;
            MEM_ADDR_O  <= '0;
            MEM_WDATA_O <= '0;
            rd_s1       <= 1'b0;
            RD_VALID_O  <= 1'b0;
            RD_DATA_O   <= '0;
        end else begin
            wcnt        <= (WR_REQ_I && !WR_GNT_O) ? (wcnt == MAXC ? wcnt : wcnt + 1'b1) : '0;
            rcnt        <= (RD_REQ_I && !RD_GNT_O) ? (rcnt == MAXC ? rcnt : rcnt + 1'b1) : '0;
            MEM_EN_O    <= WR_GNT_O | RD_GNT_O;
            MEM_WE_O    <= WR_GNT_O;
            if (WR_GNT_O) begin
                MEM_ADDR_O  <= WR_PTR_I;
                MEM_WDATA_O <= WR_DATA_I;
            end else if (RD_GNT_O) begin
                MEM_ADDR_O  <= RD_PTR_I;
            end
            // RAM samples the read command one edge later; its data is captured the edge after
            rd_s1       <= MEM_EN_O & ~MEM_WE_O;
            RD_VALID_O  <= rd_s1;
            if (rd_s1) RD_DATA_O <= MEM_RDATA_I;
        end
    end
endmodule
